vga_sync_receiver: RTL and testbench

- Receiving end of the 640x480 VGA sync interface driven by the sincronizador.
- Samples hsync/vsync and rebuilds pixel coordinates (px, py) and the video-on window.
- Locks to the incoming timing and flags any deviation from the expected line and frame geometry.
- Sits between a VGA sync source (or capture pins) and downstream pixel consumers and checkers.

---
 rtl/vga_timing_pkg.sv | 50 +++++
 rtl/sync_edge_detect.sv | 44 ++++
 rtl/vga_sync_receiver.sv | 212 +++++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//
// Shared 640x480@60 VGA timing constants and receiver FSM encoding. The same
// constants parameterise the sincronizador (sync generator), so both ends of
// the link agree on the geometry by construction.
//
// Contents:
//   H_* / V_*          base timing, in pixels / lines
//   HS_START, HS_END   first pixel of hsync pulse / first pixel after it
//   VS_START, VS_END   first line of vsync pulse / first line after it
//   SYNC_POL           sync active level (0 = active-low)
//   rx_state_e         receiver acquisition state
//   sync_is_active()   polarity normalisation helper
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_TOTAL   = 800;

    localparam int unsigned V_DISPLAY = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_TOTAL   = 525;

    localparam int unsigned HS_START = H_DISPLAY + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_DISPLAY + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    localparam logic SYNC_POL = 1'b0;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        HALIGN = 2'd1,
        VALIGN = 2'd2,
        LOCKED = 2'd3
    } rx_state_e;

    // True when the raw sync pin is at its asserted level.
    function automatic logic sync_is_active(input logic level, input logic pol);
        return level == pol;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
//
// Normalises one sync input to active-high, keeps a pix_en-gated history flop
// and reports assert/release edges relative to the previous pixel sample.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   pix_en    in   pixel-rate enable; history only advances when set
//   sync_raw  in   sync pin as driven by the source
//   act_edge  out  pulse: sync became active on this pixel
//   rel_edge  out  pulse: sync became inactive on this pixel
// -----------------------------------------------------------------------------
module sync_edge_detect #(
    parameter logic SYNC_POL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pix_en,
    input  logic sync_raw,
    output logic act_edge,
    output logic rel_edge
);
    import vga_timing_pkg::*;

    logic active;
    logic prev_q;

    assign active = sync_is_active(sync_raw, SYNC_POL);

    // History resets to "inactive" so a source idling inactive raises no edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else if (pix_en) begin
            prev_q <= active;
        end
    end

    assign act_edge = pix_en & active & ~prev_q;
    assign rel_edge = pix_en & ~active & prev_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// -----------------------------------------------------------------------------
// vga_sync_receiver
//
// Receiving end of a VGA sync link. Rebuilds pixel coordinates from hsync and
// vsync, acquires lock after one clean frame and flags any sync edge that
// lands away from its expected coordinate.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   pix_en   in   pixel-rate enable (one clk per pixel)
//   hsync    in   horizontal sync from source
//   vsync    in   vertical sync from source
//   px       out  reconstructed horizontal position
//   py       out  reconstructed vertical position
//   vidon    out  visible-area flag, only while locked
//   locked   out  timing lock achieved
//   err      out  one-clk pulse on a timing violation while locked
//   err_cnt  out  saturating violation count
// -----------------------------------------------------------------------------
module vga_sync_receiver #(
    parameter int unsigned H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int unsigned H_FP      = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_TOTAL   = vga_timing_pkg::H_TOTAL,
    parameter int unsigned V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int unsigned V_FP      = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_TOTAL   = vga_timing_pkg::V_TOTAL,
    parameter logic        SYNC_POL  = vga_timing_pkg::SYNC_POL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] px,
    output logic [9:0] py,
    output logic       vidon,
    output logic       locked,
    output logic       err,
    output logic [7:0] err_cnt
);
    import vga_timing_pkg::*;

    // Coordinates (in receiver terms) at which each sync edge is sampled once
    // aligned. Loads land on the first pixel of each pulse.
    localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] HS_LOAD   = COORD_W'(H_DISPLAY + H_FP);
    localparam logic [COORD_W-1:0] VS_LOAD   = COORD_W'(V_DISPLAY + V_FP);
    localparam logic [COORD_W-1:0] HS_ACT_PX = COORD_W'(H_DISPLAY + H_FP - 1);
    localparam logic [COORD_W-1:0] HS_REL_PX = COORD_W'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_ACT_PY = COORD_W'(V_DISPLAY + V_FP - 1);
    localparam logic [COORD_W-1:0] VS_REL_PY = COORD_W'(V_DISPLAY + V_FP + V_SYNC - 1);
    localparam logic [COORD_W-1:0] H_VIS     = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] V_VIS     = COORD_W'(V_DISPLAY);

    logic h_act, h_rel, v_act, v_rel;

    rx_state_e              state_q, state_d;
    logic [COORD_W-1:0]     px_q, px_d;
    logic [COORD_W-1:0]     py_q, py_d;
    logic                   vidon_q, vidon_d;
    logic                   err_q, err_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic h_at_end;
    logic line_wrap;
    logic h_bad;
    logic v_bad;

    // ---------------------------------------------------------------------
    // Sync edge detection
    // ---------------------------------------------------------------------
    sync_edge_detect #(
        .SYNC_POL (SYNC_POL)
    ) u_hs_edge (
        .clk      (clk),
        .rst      (rst),
        .pix_en   (pix_en),
        .sync_raw (hsync),
        .act_edge (h_act),
        .rel_edge (h_rel)
    );

    sync_edge_detect #(
        .SYNC_POL (SYNC_POL)
    ) u_vs_edge (
        .clk      (clk),
        .rst      (rst),
        .pix_en   (pix_en),
        .sync_raw (vsync),
        .act_edge (v_act),
        .rel_edge (v_rel)
    );

    // ---------------------------------------------------------------------
    // Edge position checks against the current coordinates
    // ---------------------------------------------------------------------
    assign h_at_end = (px_q == H_LAST);

    // An hsync load takes priority over the natural wrap, so no wrap then.
    assign line_wrap = pix_en & ~h_act & h_at_end;

    assign h_bad = (h_act & (px_q != HS_ACT_PX)) |
                   (h_rel & (px_q != HS_REL_PX));

    // vsync edges belong on the line wrap; this also catches a vsync edge
    // coinciding with an hsync edge, since px is never at H_LAST then.
    assign v_bad = (v_act & ~(h_at_end & (py_q == VS_ACT_PY))) |
                   (v_rel & ~(h_at_end & (py_q == VS_REL_PY)));

    // ---------------------------------------------------------------------
    // Coordinate counters
    // ---------------------------------------------------------------------
    always_comb begin
        px_d = px_q;
        py_d = py_q;
        if (pix_en) begin
            if (h_act) begin
                px_d = HS_LOAD;
            end else if (h_at_end) begin
                px_d = '0;
            end else begin
                px_d = px_q + 1'b1;
            end

            if (v_act) begin
                py_d = VS_LOAD;
            end else if (line_wrap) begin
                py_d = (py_q == V_LAST) ? '0 : py_q + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Acquisition FSM and violation reporting
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;

        case (state_q)
            SEARCH: begin
                if (h_act) begin
                    state_d = HALIGN;
                end
            end
            HALIGN: begin
                // Vertical position is still unknown here, so only hsync is
                // checked; the first vsync assertion defines the frame.
                if (h_bad) begin
                    state_d = SEARCH;
                end else if (v_act) begin
                    state_d = VALIGN;
                end
            end
            VALIGN: begin
                if (h_bad || v_bad) begin
                    state_d = SEARCH;
                end else if (v_act) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (h_bad || v_bad) begin
                    state_d = SEARCH;
                    err_d   = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase

        // Built from next-state values so it lines up with px/py.
        vidon_d = (state_d == LOCKED) & (px_d < H_VIS) & (py_d < V_VIS);
    end

    // err is a single-clk pulse, so it is rewritten every clk rather than
    // held across pix_en gaps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEARCH;
            px_q      <= '0;
            py_q      <= '0;
            vidon_q   <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            px_q      <= px_d;
            py_q      <= py_d;
            vidon_q   <= vidon_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign px      = px_q;
    assign py      = py_q;
    assign vidon   = vidon_q;
    assign locked  = (state_q == LOCKED);
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_receiver
//
// Drives the receiver from a behavioural sync source using a shrunken timing
// geometry (12 x 6 pixel frame) so that multi-frame scenarios stay short.
// A reference model derived from the edge/lock rules tracks expected outputs
// each clk; while locked, coordinates are also checked against the source's
// own pixel position.
// -----------------------------------------------------------------------------
module tb_vga_sync_receiver;

    localparam int HD  = 6;
    localparam int HFP = 2;
    localparam int HSY = 2;
    localparam int HT  = 12;
    localparam int VD  = 3;
    localparam int VFP = 1;
    localparam int VSY = 1;
    localparam int VT  = 6;
    localparam int HSS = HD + HFP;    // 8
    localparam int HSE = HSS + HSY;   // 10
    localparam int VSS = VD + VFP;    // 4
    localparam int VSE = VSS + VSY;   // 5
    localparam int FRAME = HT * VT;   // 72

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_en;
    logic       hsync;
    logic       vsync;
    logic [9:0] px;
    logic [9:0] py;
    logic       vidon;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;

    always #5 clk = ~clk;

    vga_sync_receiver #(
        .H_DISPLAY (HD),
        .H_FP      (HFP),
        .H_SYNC    (HSY),
        .H_TOTAL   (HT),
        .V_DISPLAY (VD),
        .V_FP      (VFP),
        .V_SYNC    (VSY),
        .V_TOTAL   (VT),
        .SYNC_POL  (1'b0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pix_en  (pix_en),
        .hsync   (hsync),
        .vsync   (vsync),
        .px      (px),
        .py      (py),
        .vidon   (vidon),
        .locked  (locked),
        .err     (err),
        .err_cnt (err_cnt)
    );

    // Source: (gx, gy) is the pixel presented on the next pix_en tick.
    int gx, gy, last_gx, last_gy;
    bit skip_req, vs_glitch, fault_pending;

    // Reference model
    localparam int S_SEARCH = 0, S_HALIGN = 1, S_VALIGN = 2, S_LOCKED = 3;
    int m_px, m_py, m_stage, m_cnt;
    bit m_prev_h, m_prev_v, m_err;

    int n_total, n_pass, n_fail;
    bit cmp_on;

    function automatic void check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_px = 0; m_py = 0; m_stage = S_SEARCH; m_cnt = 0;
        m_prev_h = 0; m_prev_v = 0; m_err = 0;
    endfunction

    function automatic void model_step(input bit en, input bit hs_a, input bit vs_a);
        bit ha, hr, va, vr, hbad, vbad;
        int npx, npy;
        m_err = 0;
        if (!en) return;
        ha = hs_a && !m_prev_h;
        hr = !hs_a && m_prev_h;
        va = vs_a && !m_prev_v;
        vr = !vs_a && m_prev_v;
        hbad = (ha && m_px != HSS - 1) || (hr && m_px != HSE - 1);
        vbad = (va && !(m_px == HT - 1 && m_py == VSS - 1)) ||
               (vr && !(m_px == HT - 1 && m_py == VSE - 1));
        npx = ha ? HSS : (m_px + 1) % HT;
        npy = va ? VSS : ((!ha && m_px == HT - 1) ? (m_py + 1) % VT : m_py);
        if (m_stage == S_SEARCH) begin
            if (ha) m_stage = S_HALIGN;
        end else if (m_stage == S_HALIGN) begin
            if (hbad) m_stage = S_SEARCH;
            else if (va) m_stage = S_VALIGN;
        end else if (m_stage == S_VALIGN) begin
            if (hbad || vbad) m_stage = S_SEARCH;
            else if (va) m_stage = S_LOCKED;
        end else begin
            if (hbad || vbad) begin
                m_stage = S_SEARCH;
                m_err = 1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        m_px = npx;
        m_py = npy;
        m_prev_h = hs_a;
        m_prev_v = vs_a;
    endfunction

    // One clk: inputs applied with clk low, returns at the following negedge.
    task automatic tick(input bit en);
        bit hs_a, vs_a;
        hs_a = (gx >= HSS) && (gx < HSE);
        vs_a = ((gy >= VSS) && (gy < VSE)) || vs_glitch;
        if (vs_glitch) fault_pending = 1;
        hsync  = ~hs_a;
        vsync  = ~vs_a;
        pix_en = en;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(en, hs_a, vs_a);
        if (m_stage != S_LOCKED) fault_pending = 0;
        if (en) begin
            last_gx = gx;
            last_gy = gy;
            gx++;
            if (gx == HT) begin
                gx = 0;
                gy = (gy + 1) % VT;
            end
            if (skip_req && gx == 4) begin
                gx = 5;
                skip_req = 0;
                fault_pending = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic slow_tick();
        tick(1);
        repeat (3) tick(0);
    endtask

    // Per-clk comparison against the model (and against the source once locked).
    always @(negedge clk) begin
        if (cmp_on) begin
            check("px", int'(px), m_px);
            check("py", int'(py), m_py);
            check("locked", int'(locked), int'(m_stage == S_LOCKED));
            check("vidon", int'(vidon),
                  int'(m_stage == S_LOCKED && m_px < HD && m_py < VD));
            check("err", int'(err), int'(m_err));
            check("err_cnt", int'(err_cnt), m_cnt);
            if (m_stage == S_LOCKED && !fault_pending) begin
                check("px_vs_source", int'(px), last_gx);
                check("py_vs_source", int'(py), last_gy);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nt, errs, frames, prev_py, px0, py0, errs_seen;
        bit seen;
        n_total = 0; n_pass = 0; n_fail = 0; cmp_on = 0;
        gx = 0; gy = 0; last_gx = 0; last_gy = 0;
        skip_req = 0; vs_glitch = 0; fault_pending = 0;
        rst = 1; pix_en = 0; hsync = 1; vsync = 1;
        model_reset();
        @(negedge clk);
        tick(0);
        tick(0);
        cmp_on = 1;
        check("reset_px", int'(px), 0);
        check("reset_py", int'(py), 0);
        check("reset_locked", int'(locked), 0);
        check("reset_errcnt", int'(err_cnt), 0);
        rst = 0;

        // Lock acquisition: first hsync -> HALIGN, vsync of frame 0 -> VALIGN,
        // vsync of frame 1 (pixel tick 120) -> LOCKED.
        nt = 0; seen = 0;
        while (!seen && nt < 4 * FRAME) begin
            tick(1);
            nt++;
            if (locked) seen = 1;
            else repeat (3) tick(0);
        end
        check("lock_ticks", nt, 121);

        // Three locked frames: wraps, no errors, spot vidon values.
        errs = 0; frames = 0; prev_py = int'(py);
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick(1);
            if (err) errs++;
            if (last_gx == 0 && last_gy == 0) begin
                frames++;
                check("frame_wrap_prev_py", prev_py, VT - 1);
                check("frame_wrap_px", int'(px), 0);
            end
            if (last_gx == 0 && last_gy == 2) check("line_wrap_py", int'(py), prev_py + 1);
            if (last_gx == 2 && last_gy == 1) check("vidon_visible", int'(vidon), 1);
            if (last_gx == 7 && last_gy == 1) check("vidon_hblank", int'(vidon), 0);
            prev_py = int'(py);
            repeat (3) begin
                tick(0);
                if (err) errs++;
            end
        end
        check("locked_frames", frames, 3);
        check("locked_errs", errs, 0);

        // Short line: pixel 4 skipped, hsync arrives at receiver px 6.
        skip_req = 1; seen = 0; nt = 0;
        while (!seen && nt < 2 * HT) begin
            tick(1);
            nt++;
            if (err) seen = 1;
            else repeat (3) tick(0);
        end
        check("short_err_seen", int'(seen), 1);
        check("short_errcnt", int'(err_cnt), 1);
        check("short_px_reload", int'(px), HSS);
        check("short_locked", int'(locked), 0);
        tick(0);
        check("short_err_width", int'(err), 0);
        nt = 0; seen = 0;
        while (!seen && nt < 4 * FRAME) begin
            tick(1);
            nt++;
            if (locked) seen = 1;
            else repeat (3) tick(0);
        end
        check("relock_ticks", nt, 136);

        // Stall mid-line.
        nt = 0;
        while (gx != 5 && nt < 2 * HT) begin
            slow_tick();
            nt++;
        end
        px0 = int'(px); py0 = int'(py); errs = 0;
        repeat (50) begin
            tick(0);
            if (err) errs++;
        end
        check("stall_px", int'(px), px0);
        check("stall_py", int'(py), py0);
        check("stall_locked", int'(locked), 1);
        check("stall_errs", errs, 0);

        // Misplaced vsync at source line 1.
        nt = 0;
        while (!(gx == 3 && gy == 1) && nt < 2 * FRAME) begin
            slow_tick();
            nt++;
        end
        vs_glitch = 1;
        tick(1);
        vs_glitch = 0;
        check("vsync_err", int'(err), 1);
        check("vsync_py_load", int'(py), VSS);
        check("vsync_locked", int'(locked), 0);
        check("vsync_errcnt", int'(err_cnt), 2);
        repeat (3) tick(0);
        nt = 0; seen = 0;
        while (!seen && nt < 4 * FRAME) begin
            slow_tick();
            nt++;
            if (locked) seen = 1;
        end
        check("vsync_relock", int'(seen), 1);

        // Reset mid-frame while locked.
        nt = 0;
        while (!(gx == 5 && gy == 2) && nt < 2 * FRAME) begin
            slow_tick();
            nt++;
        end
        check("prereset_locked", int'(locked), 1);
        rst = 1;
        tick(1);
        rst = 0;
        check("midreset_px", int'(px), 0);
        check("midreset_py", int'(py), 0);
        check("midreset_vidon", int'(vidon), 0);
        check("midreset_locked", int'(locked), 0);
        check("midreset_err", int'(err), 0);
        check("midreset_errcnt", int'(err_cnt), 0);

        // Saturation: 260 violations, pix_en every clk.
        errs_seen = 0;
        for (int k = 0; k < 260; k++) begin
            nt = 0;
            while (!locked && nt < 4 * FRAME) begin
                tick(1);
                nt++;
            end
            if (!locked) begin
                check("sat_relock", int'(locked), 1);
                break;
            end
            skip_req = 1; seen = 0; nt = 0;
            while (!seen && nt < 2 * HT) begin
                tick(1);
                nt++;
                if (err) seen = 1;
            end
            if (seen) errs_seen++;
            if (k == 99) check("sat_errcnt_100", int'(err_cnt), 100);
        end
        check("sat_errs_seen", errs_seen, 260);
        check("sat_errcnt", int'(err_cnt), 255);

        cmp_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
